// File: rtl/pow_nonce_search.sv
// Nonce search sequencer for a byte-wide proof-of-work hash core.
// For each nonce the block byte is XOR-ed with the nonce and sent to the core.
// The core is restarted, then enabled until it reports completion or the
// watchdog expires. The returned hash is then compared against the captured
// target. The search ends on the first hash strictly below the target, on a
// core timeout, or after nonce 8'hFF has been tried.
module pow_nonce_search #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] block_data,
  input  logic [7:0] target,
  output logic       core_rst,
  output logic       core_en,
  output logic [7:0] core_msg,
  input  logic [7:0] core_hash,
  input  logic       core_done,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic       timeout_err,
  output logic [7:0] nonce_out,
  output logic [7:0] hash_out
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    CHECK
  } state_t;

  // Last RUN cycle the watchdog tolerates before the attempt is abandoned.
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] block_data_q;
  logic [7:0] target_q;
  logic [7:0] nonce;
  logic [7:0] wdog;
  logic       load_q;

  // The message only changes when the nonce or captured block change, so it
  // is stable across the whole LOAD/RUN/CHECK attempt.
  assign core_msg = block_data_q ^ nonce;

  // NOTE: reset is ORed in combinationally so the core is held in restart for
  // the full duration of our own reset, not just from the first clock edge.
  assign core_rst = reset | load_q;

  // Search sequencer: one attempt is LOAD (core restart), RUN (core enabled,
  // watchdog counting), CHECK (hash versus target, advance or finish).
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      block_data_q <= 8'h00;
      target_q     <= 8'h00;
      nonce        <= 8'h00;
      wdog         <= 8'h00;
      load_q       <= 1'b0;
      core_en      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      found        <= 1'b0;
      timeout_err  <= 1'b0;
      nonce_out    <= 8'h00;
      hash_out     <= 8'h00;
    end else begin
      // NOTE: done and load_q are single-cycle pulses; defaulting them low
      // here means each branch only has to raise them, never clear them.
      done   <= 1'b0;
      load_q <= 1'b0;

      if (state != IDLE && abort) begin
        // Abort outranks core completion, timeout and the CHECK outcome.
        state   <= IDLE;
        busy    <= 1'b0;
        core_en <= 1'b0;
        found   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              block_data_q <= block_data;
              target_q     <= target;
              nonce        <= 8'h00;
              found        <= 1'b0;
              timeout_err  <= 1'b0;
              nonce_out    <= 8'h00;
              hash_out     <= 8'h00;
              busy         <= 1'b1;
              load_q       <= 1'b1;
              state        <= LOAD;
            end
          end

          LOAD: begin
            // Any core_done still high from the previous attempt is ignored
            // here; the core is being restarted this cycle.
            wdog    <= 8'h00;
            core_en <= 1'b1;
            state   <= RUN;
          end

          RUN: begin
            if (core_done) begin
              hash_out  <= core_hash;
              nonce_out <= nonce;
              core_en   <= 1'b0;
              state     <= CHECK;
            end else if (wdog == WDOG_LAST) begin
              timeout_err <= 1'b1;
              nonce_out   <= nonce;
              done        <= 1'b1;
              core_en     <= 1'b0;
              busy        <= 1'b0;
              state       <= IDLE;
            end else begin
              wdog <= wdog + 8'd1;
            end
          end

          CHECK: begin
            if (hash_out < target_q) begin
              found <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else if (nonce == 8'hFF) begin
              // Nonce space exhausted; the search does not wrap.
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              nonce  <= nonce + 8'd1;
              load_q <= 1'b1;
              state  <= LOAD;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pow_nonce_search.md
POW_NONCE_SEARCH -- requirements
Module: pow_nonce_search

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32: maximum RUN cycles per attempt before abort-with-error (range 2..255).
REQ-002 SHALL have port clock, input, 1: single clock; all logic on posedge clock.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: begin search; sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1: cancel search; ignored in IDLE.
REQ-006 SHALL have port block_data, input, 8: data byte to be hashed, captured on accepted start.
REQ-007 SHALL have port target, input, 8: difficulty threshold, captured on accepted start.
REQ-008 SHALL have port core_rst, output, 1: active-high restart pulse to the downstream hash core.
REQ-009 SHALL have port core_en, output, 1: enable to the hash core.
REQ-010 SHALL have port core_msg, output, 8: message byte to the hash core.
REQ-011 SHALL have port core_hash, input, 8: hash result from the core.
REQ-012 SHALL have port core_done, input, 1: core completion flag (level).
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse at search end.
REQ-015 SHALL have port found, output, 1: valid nonce found; held until next accepted start.
REQ-016 SHALL have port timeout_err, output, 1: core failed to finish; held until next accepted start.
REQ-017 SHALL have port nonce_out, output, 8: last nonce tried; held until next accepted start.
REQ-018 SHALL have port hash_out, output, 8: hash of nonce_out; held until next accepted start.

Function
REQ-019 SHALL implement states IDLE, LOAD, RUN, CHECK.
REQ-020 SHALL, on start in IDLE: capture block_data/target; set nonce=0; clear found, timeout_err, nonce_out, hash_out; go to LOAD.
REQ-021 SHALL drive core_msg = block_data_q XOR nonce in all states, stable for the whole attempt.
REQ-022 SHALL assert core_rst for exactly one cycle, in LOAD; core_en=0 in LOAD. Next state RUN.
REQ-023 SHALL assert core_en=1 throughout RUN and clear the watchdog on entering RUN.
REQ-024 SHALL ignore core_done outside RUN, so a stale flag from the prior attempt is never used.
REQ-025 SHALL, on core_done=1 in RUN, register core_hash into hash_out and nonce into nonce_out, then go to CHECK.
REQ-026 SHALL, if RUN lasts TIMEOUT cycles without core_done: set timeout_err=1, pulse done, go to IDLE; nonce_out=current nonce.
REQ-027 SHALL in CHECK compare unsigned: if hash_out < target_q, set found=1, pulse done, go to IDLE.
REQ-028 SHALL in CHECK, if no hit and nonce==8'hFF, pulse done with found=0 and go to IDLE (exhausted, no wrap).
REQ-029 SHALL in CHECK, otherwise increment nonce (8-bit) and go to LOAD.
REQ-030 SHALL give attempt latency LOAD(1) + RUN(N, where core_done is seen on Nth RUN cycle) + CHECK(1).
REQ-031 SHALL, on abort in any non-IDLE state, go to IDLE next cycle: no done pulse, found=0, core_en=0.
REQ-032 SHALL give abort priority over core_done, timeout and CHECK outcome in the same cycle.
REQ-033 SHALL ignore start while busy=1, with no effect on captured operands.
REQ-034 SHALL treat target=8'h00 as unreachable, so the search runs 256 attempts and then exhausts.

Reset
REQ-035 SHALL on reset enter IDLE and set nonce, nonce_out, hash_out, core_msg to 0, and busy, done, found, timeout_err, core_en to 0.
REQ-036 SHALL assert core_rst=1 while reset is high, so the core restarts with the block.
REQ-037 SHALL, on reset mid-search, discard all progress, emit no done pulse, and need a new start to resume.

Verification
REQ-038 SHALL cover first-try hit: core model hash=8'h10 after 3 cycles, target=8'h20, block_data=8'hA5, start -> core_msg=8'hA5, found=1, nonce_out=0, hash_out=8'h10, done 1 cycle, 5 cycles from start.
REQ-039 SHALL cover later hit: model hash = core_msg, block_data=8'h00, target=8'h04, but model returns 8'hFF for msg<3 -> found at nonce_out=3, hash_out=8'h03.
REQ-040 SHALL cover exhaustion: target=8'h00 -> 256 core_rst pulses, done with found=0, nonce_out=8'hFF.
REQ-041 SHALL cover timeout: core_done held 0, TIMEOUT=32 -> timeout_err=1, done 32 RUN cycles after LOAD, nonce_out=0.
REQ-042 SHALL cover stale/abort: core_done stuck 1 during LOAD -> ignored; abort and core_done in the same RUN cycle -> IDLE, no done, found=0.
REQ-043 SHALL cover reset mid-RUN: all outputs return to reset values next cycle; a start during busy is ignored (target unchanged).
